// File: rtl/cache_fill_ctrl.sv
// Miss-fill controller: fetches a 16-byte block as eight 16-bit reads and streams the words into the data array.
// Optional macro CACHE_FILL_STALL_CNT_EN adds a saturating stall_cycles counter output.
module cache_fill_ctrl #(
    parameter int unsigned WORDS  = 8,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic [15:0]       memory_data,
    input  logic              memory_data_valid,
    output logic              fsm_busy,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic [2:0]        fill_word,
    output logic [15:0]       fill_data,
    output logic              write_tag_array
`ifdef CACHE_FILL_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cycles
`endif
);

    localparam int unsigned IDX_W   = $clog2(WORDS);
    localparam int unsigned ISSUE_W = IDX_W + 1;
    localparam int unsigned OFF_W   = IDX_W + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ISSUE_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [IDX_W-1:0]   recv_cnt_q, recv_cnt_d;
    logic [ADDR_W-1:0]  base_addr_q, base_addr_d;

    // State, counters and block base; async reset makes every output drop at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            base_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            base_addr_q <= base_addr_d;
        end
    end

    // Next state and outputs; requests and responses advance independently.
    always_comb begin
        state_d          = state_q;
        issue_cnt_d      = issue_cnt_q;
        recv_cnt_d       = recv_cnt_q;
        base_addr_d      = base_addr_q;
        fsm_busy         = 1'b0;
        mem_read_en      = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        fill_word        = '0;
        fill_data        = '0;
        write_tag_array  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (miss_detected) begin
                    state_d     = S_FILL;
                    base_addr_d = miss_address & ~ADDR_W'((2 ** OFF_W) - 1);
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                end
            end
            S_FILL: begin
                fsm_busy         = 1'b1;
                mem_read_en      = (issue_cnt_q < ISSUE_W'(WORDS));
                memory_address   = base_addr_q + ADDR_W'({issue_cnt_q, 1'b0});
                write_data_array = memory_data_valid;
                fill_data        = memory_data;
                fill_word        = recv_cnt_q;
                if (mem_read_en) begin
                    issue_cnt_d = issue_cnt_q + ISSUE_W'(1);
                end
                if (memory_data_valid) begin
                    recv_cnt_d = recv_cnt_q + IDX_W'(1);
                    // Tag goes in with the last word so the line becomes valid atomically.
                    if (recv_cnt_q == IDX_W'(WORDS - 1)) begin
                        write_tag_array = 1'b1;
                        state_d         = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef CACHE_FILL_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    // Saturating count of busy cycles, cleared only by reset.
    always_comb begin
        stall_d = stall_q;
        if (fsm_busy && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Self-checking bench for cache_fill_ctrl: spec-timing table, randomized fills against a reference model,
// and reset / held-miss sequences. Define CACHE_FILL_STALL_CNT_EN to also exercise the stall counter.
module tb_cache_fill_ctrl;

    logic        clk;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic [15:0] memory_data;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        mem_read_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;
    logic        write_tag_array;
`ifdef CACHE_FILL_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    cache_fill_ctrl #(.WORDS(8), .ADDR_W(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data       (memory_data),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .mem_read_en       (mem_read_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .fill_word         (fill_word),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array)
`ifdef CACHE_FILL_STALL_CNT_EN
        ,
        .stall_cycles      (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: fill in flight, its block base, how many reads issued and words received.
    bit          m_busy;
    logic [15:0] m_base;
    int          m_issued;
    int          m_recv;
    logic [15:0] m_stall;

    // Observed activity since the last clear.
    int          n_wr, n_tag, n_rd;
    logic [15:0] first_rd, last_rd;
    logic [15:0] cap [8];

    typedef struct {
        logic        miss;
        logic        valid;
        logic [15:0] data;
        logic        e_busy;
        logic        e_rd;
        logic [15:0] e_addr;
        logic        e_wda;
        logic [2:0]  e_word;
        logic [15:0] e_fd;
        logic        e_wta;
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [38:0] act_vec();
        return {fsm_busy, mem_read_en, memory_address, write_data_array, fill_word, fill_data, write_tag_array};
    endfunction

    function automatic logic [38:0] exp_vec();
        logic        rd, wda, wta;
        logic [15:0] a, fd;
        logic [2:0]  w;
        rd  = m_busy && (m_issued < 8);
        a   = m_busy ? 16'(m_base + 16'(2 * m_issued)) : 16'h0;
        wda = m_busy && memory_data_valid;
        w   = m_busy ? 3'(m_recv) : 3'd0;
        fd  = m_busy ? memory_data : 16'h0;
        wta = m_busy && memory_data_valid && (m_recv == 7);
        return {1'(m_busy), rd, a, wda, w, fd, wta};
    endfunction

    task automatic model_reset();
        m_busy = 0; m_base = '0; m_issued = 0; m_recv = 0; m_stall = '0;
    endtask

    task automatic clear_obs();
        n_wr = 0; n_tag = 0; n_rd = 0; first_rd = '0; last_rd = '0;
        for (int i = 0; i < 8; i++) cap[i] = 'x;
    endtask

    // Apply inputs at posedge+1, compare against the model at posedge+4.
    task automatic drive(input logic miss, input logic [15:0] addr, input logic valid, input logic [15:0] data);
        miss_detected     = miss;
        miss_address      = addr;
        memory_data_valid = valid;
        memory_data       = data;
        #3;
        check("cycle_outputs", 64'(act_vec()), 64'(exp_vec()));
`ifdef CACHE_FILL_STALL_CNT_EN
        check("stall_cycles", 64'(stall_cycles), 64'(m_stall));
`endif
        if (write_data_array) begin
            cap[fill_word] = fill_data;
            n_wr++;
        end
        if (write_tag_array) n_tag++;
        if (mem_read_en) begin
            if (n_rd == 0) first_rd = memory_address;
            last_rd = memory_address;
            n_rd++;
        end
    endtask

    task automatic advance();
        if (m_busy && m_stall != 16'hFFFF) m_stall++;
        if (!m_busy) begin
            if (miss_detected) begin
                m_busy = 1; m_base = {miss_address[15:4], 4'h0}; m_issued = 0; m_recv = 0;
            end
        end else begin
            if (m_issued < 8) m_issued++;
            if (memory_data_valid) begin
                m_recv++;
                if (m_recv == 8) m_busy = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic miss, input logic [15:0] addr, input logic valid, input logic [15:0] data);
        drive(miss, addr, valid, data);
        advance();
    endtask

    // Pipelined memory of latency lat; optionally keeps miss high until the tag write.
    task automatic run_fill(input logic [15:0] addr, input int lat, input bit hold_miss);
        logic [15:0] d [8];
        clear_obs();
        for (int c = 0; c <= 9 + lat; c++) begin
            logic v;
            logic [15:0] dat;
            v   = (c >= 1 + lat) && (c <= 8 + lat);
            dat = 16'($urandom);
            if (v) d[c - 1 - lat] = dat;
            step((c == 0) || (hold_miss && c <= 8 + lat), addr, v, dat);
        end
        check("fill_data_writes", 64'(n_wr), 64'd8);
        check("fill_tag_writes", 64'(n_tag), 64'd1);
        check("fill_reads", 64'(n_rd), 64'd8);
        check("fill_first_addr", 64'(first_rd), 64'({addr[15:4], 4'h0}));
        check("fill_last_addr", 64'(last_rd), 64'({addr[15:4], 4'hE}));
        for (int i = 0; i < 8; i++) check("fill_word_data", 64'(cap[i]), 64'(d[i]));
        check("fill_done_idle", 64'(fsm_busy), 64'd0);
    endtask

    task automatic run_irregular(input logic [15:0] addr);
        logic [15:0] sent [$];
        int gap;
        clear_obs();
        step(1'b1, addr, 1'b0, 16'h0);
        gap = 1;
        for (int c = 0; c < 60 && (m_busy || sent.size() < 8); c++) begin
            logic v;
            logic [15:0] dat;
            v   = (gap == 0) && (sent.size() < 8);
            dat = 16'($urandom);
            if (v) begin
                sent.push_back(dat);
                gap = $urandom_range(3, 0);
            end else if (gap > 0) begin
                gap--;
            end
            step(1'b0, 16'($urandom), v, dat);
        end
        check("irr_done_idle", 64'(fsm_busy), 64'd0);
        check("irr_data_writes", 64'(n_wr), 64'd8);
        check("irr_tag_writes", 64'(n_tag), 64'd1);
        for (int i = 0; i < 8 && i < sent.size(); i++) check("irr_word_data", 64'(cap[i]), 64'(sent[i]));
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        miss_detected = 1'b0; miss_address = '0; memory_data = '0; memory_data_valid = 1'b0;
        model_reset();
        clear_obs();
        #2;
        check("reset_outputs", 64'(act_vec()), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;

        // Spec timing for a miss at 0x1236 with latency 4.
        for (int c = 0; c < 15; c++) begin
            tbl[c].miss   = (c == 0);
            tbl[c].valid  = (c >= 5) && (c <= 12);
            tbl[c].data   = 16'(16'hA000 + c);
            tbl[c].e_busy = (c >= 1) && (c <= 12);
            tbl[c].e_rd   = (c >= 1) && (c <= 8);
            tbl[c].e_addr = 16'(16'h1230 + 2 * (c - 1));
            tbl[c].e_wda  = tbl[c].valid;
            tbl[c].e_word = tbl[c].valid ? 3'(c - 5) : 3'd0;
            tbl[c].e_fd   = tbl[c].e_busy ? tbl[c].data : 16'h0;
            tbl[c].e_wta  = (c == 12);
        end
        for (int c = 0; c < 15; c++) begin
            drive(tbl[c].miss, 16'h1236, tbl[c].valid, tbl[c].data);
            check("tbl_busy", 64'(fsm_busy), 64'(tbl[c].e_busy));
            check("tbl_rd", 64'(mem_read_en), 64'(tbl[c].e_rd));
            if (tbl[c].e_rd) check("tbl_addr", 64'(memory_address), 64'(tbl[c].e_addr));
            check("tbl_wda", 64'(write_data_array), 64'(tbl[c].e_wda));
            check("tbl_word", 64'(fill_word), 64'(tbl[c].e_word));
            check("tbl_fdata", 64'(fill_data), 64'(tbl[c].e_fd));
            check("tbl_wta", 64'(write_tag_array), 64'(tbl[c].e_wta));
            advance();
        end

        // Top block of the address space: no wrap past 0xFFFE.
        run_fill(16'hFFF2, 2, 1'b0);
        run_fill(16'h0007, 1, 1'b0);

        // Irregular response gaps with random data and addresses.
        for (int k = 0; k < 6; k++) run_irregular(16'($urandom));

        // Reset after three returned words.
        clear_obs();
        step(1'b1, 16'h2008, 1'b0, 16'h0);
        step(1'b0, 16'h0, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1, 16'(16'h5500 + i));
        drive(1'b0, 16'h0, 1'b1, 16'h55AA);
        check("pre_reset_busy", 64'(fsm_busy), 64'd1);
        rst = 1'b0;
        #1;
        check("mid_reset_outputs", 64'(act_vec()), 64'd0);
        check("mid_reset_tag_writes", 64'(n_tag), 64'd0);
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        clear_obs();
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b1, 16'(16'hDEAD + i));
        check("stale_writes", 64'(n_wr + n_tag), 64'd0);
        run_fill(16'h0040, 3, 1'b0);

        // Miss held through the whole fill, dropped on the return-to-idle cycle.
        run_fill(16'h3456, 4, 1'b1);
        clear_obs();
        for (int i = 0; i < 3; i++) step(1'b0, 16'h3456, 1'b0, 16'h0);
        check("no_second_fill", 64'(n_rd), 64'd0);

`ifdef CACHE_FILL_STALL_CNT_EN
        apply_reset();
        run_fill(16'h1000, 4, 1'b0);
        run_fill(16'h2000, 4, 1'b0);
        check("stall_two_fills", 64'(stall_cycles), 64'd24);
        step(1'b1, 16'h4000, 1'b0, 16'h0);
        for (int i = 0; i < 70000; i++) step(1'b0, 16'h0, 1'b0, 16'h0);
        check("stall_saturated", 64'(stall_cycles), 64'hFFFF);
        for (int i = 0; i < 8; i++) step(1'b0, 16'h0, 1'b1, 16'(i));
        check("stall_fill_done", 64'(fsm_busy), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Miss-handling controller for the 2-way data cache. When the cache signals a miss, it fetches the whole 16-byte block from main memory as eight sequential 16-bit reads and streams each returned word into the data array. It then writes the tag/valid/LRU entry into the metadata array together with the last word. It sits between the cache's miss detector and the multi-cycle memory, and its busy flag stalls the pipeline.

## Interface
- WORDS, 8, words per block; fixed at 8, so 3-bit word index and 16-byte blocks
- ADDR_W, 16, address width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low; clears all state and outputs
- miss_detected  in  1  cache miss flag from the cache
- miss_address  in  ADDR_W  byte address of the missing access
- memory_data  in  16  read data returned by memory
- memory_data_valid  in  1  memory_data valid this cycle
- fsm_busy  out  1  fill in progress; pipeline stall
- mem_read_en  out  1  memory read request this cycle
- memory_address  out  ADDR_W  byte address of the current read request
- write_data_array  out  1  write fill_data into the data array this cycle
- fill_word  out  3  word index within the block, drives the word decoder
- fill_data  out  16  data-array write data
- write_tag_array  out  1  write the metadata entry for the victim way this cycle

## Operation
- States: IDLE, FILL. Counters: issue_cnt (0..8), recv_cnt (0..7). Base register: base_addr.
- IDLE:
  - All outputs are 0.
  - memory_data_valid is ignored.
  - When miss_detected=1, latch base_addr={miss_address[15:4],4'b0000}, clear both counters, and go to FILL.
- FILL:
  - fsm_busy=1.
- Request side:
  - mem_read_en=1 while issue_cnt<8.
  - memory_address=base_addr+2*issue_cnt.
  - issue_cnt increments every cycle until it reaches 8.
  - Memory accepts one request per cycle and has no back-pressure.
- Response side:
  - write_data_array=memory_data_valid.
  - fill_data=memory_data (combinational pass-through).
  - fill_word=recv_cnt.
  - recv_cnt increments on each valid word.
- Completion:
  - On a valid word with recv_cnt=7, write_data_array=1 and write_tag_array=1 in the same cycle.
  - The next state is IDLE.
- Address arithmetic is modulo 2^16. A block never crosses a 16-byte boundary, so offsets are 0x0..0xE.
- miss_detected is ignored while in FILL.
- Returning to IDLE takes one cycle. By then the metadata shows a hit, so miss_detected is low and no second fill starts.
- Responses may arrive while requests are still issuing. Order is in-order; no IDs.

## Timing
- Reset values: state IDLE, counters 0, base_addr 0, every output 0.
- Memory latency L (cycles from request to valid) is external.
- Cycle 0: miss_detected seen in IDLE.
- Cycles 1..8: fsm_busy=1, with requests at offsets 0,2,…,14.
- With a pipelined memory of latency L, data writes fall on cycles 1+L..8+L, and write_tag_array is asserted on cycle 8+L.
- Cycle 9+L: fsm_busy=0.
- If memory_data_valid arrives in FILL before any request, it is still counted. The memory contract forbids this.
- memory_data_valid in IDLE, including stale returns after a reset, is dropped and produces no array write.
- Reset asserted mid-FILL:
  - Outputs clear immediately, without waiting for a clock edge.
  - The FSM returns to IDLE.
  - The partial block is left with its tag unwritten, so it stays invalid.

## Configuration
- CACHE_FILL_STALL_CNT_EN defined:
  - Adds output stall_cycles (16 bits).
  - The counter increments on every clk edge at which fsm_busy=1.
  - It saturates at 16'hFFFF.
  - It clears on rst and on nothing else.
- Undefined: no port, no counter logic.

## Test plan
- Miss at 0x1236, L=4:
  - memory_address 0x1230..0x123E on cycles 1..8.
  - write_data_array on cycles 5..12, with fill_word 0..7.
  - write_tag_array only on cycle 12.
  - fsm_busy falls on cycle 13.
- Miss at 0xFFF2:
  - Addresses 0xFFF0..0xFFFE; no wrap into the next block.
- Irregular memory_data_valid (gaps of 0–3 cycles, random data):
  - Each data word lands at the correct fill_word.
  - Exactly 8 data writes and 1 tag write.
- Reset:
  - Assert rst=0 after 3 words returned: all outputs 0 immediately, no tag write.
  - After release, stale memory_data_valid pulses produce no writes.
  - A new miss at 0x0040 fills cleanly.
- miss_detected held high through a fill, then dropped:
  - Exactly one fill; fsm_busy is low for one cycle at the end, and no second fill starts.
- With CACHE_FILL_STALL_CNT_EN and L=4:
  - Two consecutive fills give stall_cycles=24.
  - Forcing 70000 busy cycles gives stall_cycles=16'hFFFF.
